evolution_window_feeder: RTL and testbench
==========================================

// Module: evolution_window_feeder
// PURPOSE
// - Upstream stage of the per-block evolution logic: walks the cell grid in RAM, row-major.
// - For each target row r and block b, fetches rows r-1, r, r+1 of that block.
// - Presents them as a 3-row window plus the previously presented window (left neighbour).
// - Uses a valid/ready handshake; one full grid pass is one generation.
// PARAMETERS
// - BLOCK_LEN  10   cells per RAM word (one block)
// - ROWS       100  grid rows
// - COLS_BLK   10   blocks per row (grid width = COLS_BLK*BLOCK_LEN)
// - ADDR_W     $clog2(ROWS*COLS_BLK)  RAM address width
// PORTS
// - clk              in   1            system clock
// - rst_n            in   1            synchronous, active-low reset
// - start            in   1            begin one generation pass (sampled only in IDLE)
// - mem_rd_en        out  1            RAM read strobe
// - mem_addr         out  ADDR_W       word address = row*COLS_BLK + blk
// - mem_rdata        in   BLOCK_LEN    read data, valid exactly 1 cycle after mem_rd_en
// - win_valid        out  1            window valid
// - win_ready        in   1            consumer accepts the window
// - line_status      out  3*BLOCK_LEN  {row r+1, row r, row r-1} of block b
// - last_line_status out  3*BLOCK_LEN  same layout, block b-1
// - win_row          out  $clog2(ROWS)           target row r
// - win_blk          out  $clog2(COLS_BLK+1)     block b; COLS_BLK marks the flush window
// - win_flush        out  1            flush window: only completes block COLS_BLK-1's last cell
// - gen_done         out  1            1-cycle pulse after the final handshake of the pass
// BEHAVIOUR
// - Reset (sync, rst_n=0): state IDLE; all outputs 0.
//   Reset mid-pass abandons the pass; no gen_done.
// - FSM: IDLE -start-> RD0 -> RD1 -> RD2 -> CAP -> PRESENT -hs-> RD0 | DONE -> IDLE.
//   - RDk issues the read for row r-1+k; data is captured one cycle later.
//   - Minimum 5 cycles per window.
// - Row index outside 0..ROWS-1: mem_rd_en stays 0 that cycle; zeros are substituted.
// - Bit order: line_status[k*BLOCK_LEN+j] = row r-1+k, column j of the block.
// - PRESENT: win_valid=1. All window outputs are stable until win_valid && win_ready.
// - On handshake:
//   - last_line_status <= line_status.
//   - b increments; after b==COLS_BLK (flush), r increments and b=0.
// - First window of a row (b=0): last_line_status = 0.
// - Flush window (b=COLS_BLK): line_status = 0, win_flush=1.
// - Windows per row: COLS_BLK+1. Windows per pass: ROWS*(COLS_BLK+1).
// - Handshake on the flush window of row ROWS-1:
//   - gen_done=1 for exactly one cycle (DONE), then IDLE.
// - start while not IDLE is ignored.
// - win_ready held high with no valid window has no effect.
// CONFIGURATION
// - Macro EVOLUTION_FEEDER_WRAP_EN.
// - Defined: toroidal grid.
//   - Row -1 reads row ROWS-1; row ROWS reads row 0 (mem_rd_en asserted).
//   - Each row starts with a hidden prefetch of block COLS_BLK-1: 3 reads into
//     last_line_status, no window presented.
//   - The flush window carries block 0 data in line_status instead of zeros.
// - Undefined: dead boundary as described above; no prefetch.
// TESTING (ROWS=3, COLS_BLK=2, BLOCK_LEN=4 unless noted)
// - Reset, then start=1 for 1 cycle, win_ready=1 -> exactly 9 handshakes, then one gen_done
//   pulse; first mem_rd_en addresses 0 then 2 (row -1 skipped).
// - RAM word n = n+1 (4 bits), r=1, b=1 -> line_status={4'h6,4'h4,4'h2};
//   last_line_status={4'h5,4'h3,4'h1}.
// - win_ready=0 for 10 cycles in PRESENT -> win_valid and all window outputs unchanged;
//   mem_rd_en=0 throughout.
// - rst_n=0 for 1 cycle mid-pass (r=1, b=1) -> next cycle all outputs 0, IDLE;
//   new start replays from r=0, b=0.
// - Row 0, b=2 -> win_flush=1, line_status=0; next window r=1, b=0, last_line_status=0.
// - WRAP_EN, r=0, b=0 -> hidden prefetch reads addr 5, 1, 3.
//   Window then shows line_status rows {4'h3,4'h1,4'h5}; flush line_status={4'h3,4'h1,4'h5}.

Source files
------------

// File: rtl/evolution_window_feeder.sv
// Row-major grid walker feeding 3-row block windows to the evolution stage.
// Define EVOLUTION_FEEDER_WRAP_EN for a toroidal grid.
module evolution_window_feeder #(
  parameter int BLOCK_LEN = 10,
  parameter int ROWS      = 100,
  parameter int COLS_BLK  = 10,
  parameter int ADDR_W    = $clog2(ROWS*COLS_BLK)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic [BLOCK_LEN-1:0]           mem_rdata,
  output logic                           win_valid,
  input  logic                           win_ready,
  output logic [3*BLOCK_LEN-1:0]         line_status,
  output logic [3*BLOCK_LEN-1:0]         last_line_status,
  output logic [$clog2(ROWS)-1:0]        win_row,
  output logic [$clog2(COLS_BLK+1)-1:0]  win_blk,
  output logic                           win_flush,
  output logic                           gen_done
);

  localparam int RW = $clog2(ROWS);
  localparam int BW = $clog2(COLS_BLK+1);
  localparam int XW = RW + 2;
`ifdef EVOLUTION_FEEDER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_CAP, S_PRES, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [RW-1:0]          r_row;
  logic [BW-1:0]          r_blk;
  logic                   r_pre;
  logic [3*BLOCK_LEN-1:0] r_line, r_last;
  logic                   r_cap_go, r_cap_en, r_cap_pre;
  logic [1:0]             r_cap_k;

  logic                   w_rd_st;
  logic [1:0]             w_k;
  logic                   w_flush, w_last_row, w_hs;
  logic [XW-1:0]          w_x;
  logic                   w_in;
  logic [RW-1:0]          w_rrow;
  logic [BW-1:0]          w_rblk;
  logic [BLOCK_LEN-1:0]   w_data;

  assign w_flush    = (r_blk == BW'(COLS_BLK));
  assign w_last_row = (r_row == RW'(ROWS-1));
  assign w_hs       = (r_state == S_PRES) && win_ready;
  assign w_data     = r_cap_en ? mem_rdata : '0;

  always_comb begin
    w_rd_st = 1'b0;
    w_k     = 2'd0;
    unique case (1'b1)
      (r_state == S_RD0): begin w_rd_st = 1'b1; w_k = 2'd0; end
      (r_state == S_RD1): begin w_rd_st = 1'b1; w_k = 2'd1; end
      (r_state == S_RD2): begin w_rd_st = 1'b1; w_k = 2'd2; end
      default: ;
    endcase
  end

  // w_x is the source row plus one, so row -1 maps to 0
  always_comb begin
    w_x  = XW'(r_row) + XW'(w_k);
    w_in = (w_x != '0) && (w_x <= XW'(ROWS));
    if (w_x == '0)
      w_rrow = RW'(ROWS-1);
    else if (!w_in)
      w_rrow = '0;
    else
      w_rrow = RW'(w_x - XW'(1));
    if (r_pre)
      w_rblk = BW'(COLS_BLK-1);
    else if (w_flush)
      w_rblk = '0;
    else
      w_rblk = r_blk;
  end

  assign mem_rd_en = w_rd_st && (w_in || WRAP) && (!w_flush || WRAP || r_pre);
  assign mem_addr  = mem_rd_en ?
    ADDR_W'(int'(w_rrow)*COLS_BLK + int'(w_rblk)) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RD0;
      S_RD0:  w_next = S_RD1;
      S_RD1:  w_next = S_RD2;
      S_RD2:  w_next = S_CAP;
      S_CAP:  w_next = r_pre ? S_RD0 : S_PRES;
      S_PRES: if (win_ready)
                w_next = (w_flush && w_last_row) ? S_DONE : S_RD0;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_blk     <= '0;
      r_pre     <= 1'b0;
      r_line    <= '0;
      r_last    <= '0;
      r_cap_go  <= 1'b0;
      r_cap_en  <= 1'b0;
      r_cap_pre <= 1'b0;
      r_cap_k   <= '0;
    end else begin
      r_cap_go  <= w_rd_st;
      r_cap_en  <= mem_rd_en;
      r_cap_k   <= w_k;
      r_cap_pre <= r_pre;
      // prefetch slots land in the left-neighbour window
      if (r_cap_go) begin
        for (int i = 0; i < 3; i++) begin
          if (r_cap_k == 2'(i)) begin
            if (r_cap_pre) r_last[i*BLOCK_LEN +: BLOCK_LEN] <= w_data;
            else           r_line[i*BLOCK_LEN +: BLOCK_LEN] <= w_data;
          end
        end
      end
      if (r_state == S_IDLE && start) begin
        r_row  <= '0;
        r_blk  <= '0;
        r_last <= '0;
        r_pre  <= WRAP;
      end
      if (r_state == S_CAP) r_pre <= 1'b0;
      if (w_hs) begin
        r_last <= r_line;
        if (w_flush) begin
          r_blk <= '0;
          if (!w_last_row) begin
            r_row <= r_row + RW'(1);
            r_pre <= WRAP;
          end
        end else begin
          r_blk <= r_blk + BW'(1);
        end
      end
    end
  end

  assign win_valid        = (r_state == S_PRES);
  assign gen_done         = (r_state == S_DONE);
  assign line_status      = r_line;
  assign last_line_status = r_last;
  assign win_row          = r_row;
  assign win_blk          = r_blk;
  assign win_flush        = win_valid && w_flush;

endmodule

// File: tb/tb_evolution_window_feeder.sv
// Directed bench for evolution_window_feeder on a 3x2-block grid of 4-bit blocks.
// RAM word n holds n+1.
module tb_evolution_window_feeder;

  localparam int BL = 4;
  localparam int NR = 3;
  localparam int NB = 2;
  localparam int AW = $clog2(NR*NB);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          win_ready = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [BL-1:0] mem_rdata = '0;
  logic          win_valid;
  logic [3*BL-1:0] line_status, last_line_status;
  logic [1:0]    win_row;
  logic [1:0]    win_blk;
  logic          win_flush, gen_done;

  int n_vec = 0;
  int n_err = 0;

  evolution_window_feeder #(
    .BLOCK_LEN(BL), .ROWS(NR), .COLS_BLK(NB), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .win_valid(win_valid), .win_ready(win_ready),
    .line_status(line_status), .last_line_status(last_line_status),
    .win_row(win_row), .win_blk(win_blk),
    .win_flush(win_flush), .gen_done(gen_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= BL'(int'(mem_addr) + 1);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic logic [3*BL-1:0] exp_line(int r, int b);
    logic [3*BL-1:0] v;
    v = '0;
    if (b < NB)
      for (int k = 0; k < 3; k++)
        if (r-1+k >= 0 && r-1+k < NR)
          v[k*BL +: BL] = BL'((r-1+k)*NB + b + 1);
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    logic [63:0] all;
    all = {mem_rd_en, 3'(mem_addr), win_valid, line_status,
           last_line_status, win_row, win_blk, win_flush, gen_done};
    check(tag, all, 64'h0);
  endtask

  initial begin
    bit ok;
    bit seen;
    int hs, dn, nrd, er, eb;
    logic [AW-1:0] ra [3];

    tick(); tick();
    check_idle_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

`ifdef EVOLUTION_FEEDER_WRAP_EN
    start = 1'b1; win_ready = 1'b0;
    tick();
    start = 1'b0;
    nrd = 0;
    for (int c = 0; c < 40 && !win_valid; c++) begin
      if (mem_rd_en && nrd < 3) begin
        ra[nrd] = mem_addr;
        nrd++;
      end
      tick();
    end
    check("wrap_valid", win_valid, 1);
    check("wrap_pref0", ra[0], 5);
    check("wrap_pref1", ra[1], 1);
    check("wrap_pref2", ra[2], 3);
    check("wrap_line", line_status, 12'h315);
    check("wrap_last", last_line_status, 12'h426);
    check("wrap_rb", {win_row, win_blk}, 0);
    win_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (win_valid && win_blk == 2'd2) seen = 1'b1;
    end
    check("wrap_flush_seen", seen, 1);
    check("wrap_flush_line", line_status, 12'h315);
    check("wrap_flush_flag", win_flush, 1);
`else
    // full pass with ready held high; a mid-pass start must be ignored
    start = 1'b1; win_ready = 1'b1;
    tick();
    start = 1'b0;
    hs = 0; dn = 0; nrd = 0; er = 0; eb = 0;
    for (int c = 0; c < 80; c++) begin
      start = 1'b0;
      if (mem_rd_en && nrd < 2) begin
        ra[nrd] = mem_addr;
        nrd++;
      end
      if (win_valid) begin
        check("win_row", win_row, er);
        check("win_blk", win_blk, eb);
        check("win_line", line_status, exp_line(er, eb));
        check("win_last", last_line_status,
              (eb == 0) ? '0 : exp_line(er, eb-1));
        check("win_flush", win_flush, eb == NB);
        if (er == 1 && eb == 1) begin
          check("r1b1_line", line_status, 12'h642);
          check("r1b1_last", last_line_status, 12'h531);
        end
        hs++;
        if (hs == 3) start = 1'b1;
        if (eb == NB) begin eb = 0; er++; end
        else eb++;
      end
      if (gen_done) dn++;
      tick();
    end
    check("handshakes", hs, 9);
    check("gen_done_pulses", dn, 1);
    check("first_rd_addr", ra[0], 0);
    check("second_rd_addr", ra[1], 2);
    check("idle_after_pass", {win_valid, gen_done}, 0);

    // stall in PRESENT
    win_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, ok);
    check("stall_valid_seen", ok, 1);
    seen = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!win_valid || line_status !== 12'h310 || mem_rd_en ||
          last_line_status !== '0 || win_row !== 0 || win_blk !== 0)
        seen = 1'b0;
    end
    check("stall_hold", seen, 1);
    check("stall_line", line_status, 12'h310);

    // reset at r=1, b=1
    win_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      tick();
      if (win_valid && win_row == 2'd1 && win_blk == 2'd1) seen = 1'b1;
    end
    check("r1b1_reached", seen, 1);
    win_ready = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("midpass_reset");
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (gen_done || win_valid) seen = 1'b1;
    end
    check("no_done_after_reset", seen, 0);
    start = 1'b1; win_ready = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(20, ok);
    check("replay_valid", ok, 1);
    check("replay_rb", {win_row, win_blk}, 0);
    check("replay_line", line_status, 12'h310);
    check("replay_last", last_line_status, 0);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tick();
      if (gen_done) seen = 1'b1;
    end
    check("replay_done", seen, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
